noc_port_mux: RTL and testbench

Two-input flit multiplexer for the NoC router output stage: one of two input ports (data, valid, virtual-channel tag) is forwarded to a single output port under a one-hot select. Used in router datapath and in energy characterization runs, where random and walking-ones payloads are streamed through it. The output is registered by default; a combinational mode is selectable.

---
 rtl/noc_port_mux_if.sv | 29 ++
 rtl/noc_port_mux.sv | 60 ++++++
 tb/tb_noc_port_mux.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/noc_port_mux_if.sv
// Bundle of the two flit input ports, one-hot select and the muxed output port.
// The slave modport is the mux side; the master modport is the side that drives and observes it.
interface noc_port_mux_if #(
  parameter int DATA_W = 64,
  parameter int VCH_W  = 2,
  parameter int SEL_W  = 5
);
  logic [DATA_W-1:0] idata_0;
  logic              ivalid_0;
  logic [VCH_W-1:0]  ivch_0;
  logic [DATA_W-1:0] idata_1;
  logic              ivalid_1;
  logic [VCH_W-1:0]  ivch_1;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VCH_W-1:0]  ovch;
  logic              sel_err;

  modport master (
    output idata_0, ivalid_0, ivch_0, idata_1, ivalid_1, ivch_1, sel,
    input  odata, ovalid, ovch, sel_err
  );

  modport slave (
    input  idata_0, ivalid_0, ivch_0, idata_1, ivalid_1, ivch_1, sel,
    output odata, ovalid, ovch, sel_err
  );
endinterface

// File: rtl/noc_port_mux.sv
// Two-port flit mux for the router output stage; one-hot select, optional output register.
// Any select other than exactly bit0 or exactly bit1 idles the output and flags sel_err.
module noc_port_mux #(
  parameter int DATA_W  = 64,
  parameter int VCH_W   = 2,
  parameter int SEL_W   = 5,
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_,
  noc_port_mux_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              vld;
    logic [VCH_W-1:0]  vch;
    logic              err;
  } out_t;

  out_t mux_d;
  out_t res;

  // Invalid flits on the selected port still pass through; ovalid qualifies them.
  always_comb begin
    mux_d = '0;
    if (bus.sel == SEL_W'(1)) begin
      mux_d.data = bus.idata_0;
      mux_d.vld  = bus.ivalid_0;
      mux_d.vch  = bus.ivch_0;
    end else if (bus.sel == SEL_W'(2)) begin
      mux_d.data = bus.idata_1;
      mux_d.vld  = bus.ivalid_1;
      mux_d.vch  = bus.ivch_1;
    end else begin
      mux_d.err  = 1'b1;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      out_t out_q;
      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) out_q <= '0;
        else       out_q <= mux_d;
      end
      assign res = out_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_;
      assign res = mux_d;
    end
  endgenerate

  assign bus.odata   = res.data;
  assign bus.ovalid  = res.vld;
  assign bus.ovch    = res.vch;
  assign bus.sel_err = res.err;

endmodule

// File: tb/tb_noc_port_mux.sv
// Scoreboard bench for noc_port_mux: registered instance checked by a decoupled monitor,
// combinational instance checked for zero-latency response.
module tb_noc_port_mux;
  localparam int DATA_W = 64;
  localparam int VCH_W  = 2;
  localparam int SEL_W  = 5;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] data;
    logic              vld;
    logic [VCH_W-1:0]  vch;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  noc_port_mux_if #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(SEL_W)) bus_r ();
  noc_port_mux_if #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(SEL_W)) bus_c ();

  noc_port_mux #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(SEL_W), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst_(rst_), .bus(bus_r)
  );
  noc_port_mux #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(SEL_W), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_(rst_), .bus(bus_c)
  );

  task automatic check(input string nm, input logic [DATA_W-1:0] ad, input logic av,
                       input logic [VCH_W-1:0] ac, input logic ae,
                       input logic [DATA_W-1:0] ed, input logic ev,
                       input logic [VCH_W-1:0] ec, input logic ee);
    n_vec++;
    if ({ad, av, ac, ae} !== {ed, ev, ec, ee}) begin
      n_err++;
      $display("FAIL %s: got data=%h vld=%b vch=%0d err=%b, want data=%h vld=%b vch=%0d err=%b",
               nm, ad, av, ac, ae, ed, ev, ec, ee);
    end
  endtask

  // Monitor: one registered result per cycle, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst_ && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, bus_r.odata, bus_r.ovalid, bus_r.ovch, bus_r.sel_err,
              e.data, e.vld, e.vch, e.err);
      end
    end
  end

  task automatic drive_r(input logic [SEL_W-1:0] s,
                         input logic [DATA_W-1:0] d0, input logic v0, input logic [VCH_W-1:0] c0,
                         input logic [DATA_W-1:0] d1, input logic v1, input logic [VCH_W-1:0] c1);
    bus_r.sel = s;
    bus_r.idata_0 = d0; bus_r.ivalid_0 = v0; bus_r.ivch_0 = c0;
    bus_r.idata_1 = d1; bus_r.ivalid_1 = v1; bus_r.ivch_1 = c1;
  endtask

  task automatic apply(input string nm, input logic [SEL_W-1:0] s,
                       input logic [DATA_W-1:0] d0, input logic v0, input logic [VCH_W-1:0] c0,
                       input logic [DATA_W-1:0] d1, input logic v1, input logic [VCH_W-1:0] c1,
                       input logic [DATA_W-1:0] ed, input logic ev,
                       input logic [VCH_W-1:0] ec, input logic ee);
    @(negedge clk);
    drive_r(s, d0, v0, c0, d1, v1, c1);
    exp_q.push_back('{nm, ed, ev, ec, ee});
  endtask

  task automatic apply_c(input string nm, input logic [SEL_W-1:0] s,
                         input logic [DATA_W-1:0] d0, input logic v0, input logic [VCH_W-1:0] c0,
                         input logic [DATA_W-1:0] d1, input logic v1, input logic [VCH_W-1:0] c1,
                         input logic [DATA_W-1:0] ed, input logic ev,
                         input logic [VCH_W-1:0] ec, input logic ee);
    @(negedge clk);
    bus_c.sel = s;
    bus_c.idata_0 = d0; bus_c.ivalid_0 = v0; bus_c.ivch_0 = c0;
    bus_c.idata_1 = d1; bus_c.ivalid_1 = v1; bus_c.ivch_1 = c1;
    #1;
    check(nm, bus_c.odata, bus_c.ovalid, bus_c.ovch, bus_c.sel_err, ed, ev, ec, ee);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] f1, r0;
    logic [27:0]       pay;
    int                drain;

    drive_r(5'b00001, '1, 1'b1, 2'd3, 64'h0, 1'b0, 2'd0);
    bus_c.sel = '0;
    bus_c.idata_0 = '0; bus_c.ivalid_0 = 1'b0; bus_c.ivch_0 = '0;
    bus_c.idata_1 = '0; bus_c.ivalid_1 = 1'b0; bus_c.ivch_1 = '0;

    // Reset asserted before any clock edge: outputs must clear asynchronously.
    #2 rst_ = 1'b0;
    #1 check("rst_async", bus_r.odata, bus_r.ovalid, bus_r.ovch, bus_r.sel_err, '0, 1'b0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("rst_held", bus_r.odata, bus_r.ovalid, bus_r.ovch, bus_r.sel_err, '0, 1'b0, 2'd0, 1'b0);

    @(negedge clk);
    rst_ = 1'b1;
    exp_q.push_back('{"rst_release", '1, 1'b1, 2'd3, 1'b0});

    // Port 1 stream: head, walking-ones body, tail; random traffic on port 0.
    for (int i = 0; i < 20; i++) begin
      pay = 28'h1 << (i - 1);
      if (i == 0)       f1 = 64'h1000_0000_0000_00A5;
      else if (i == 19) f1 = 64'h3000_0000_0000_005A;
      else              f1 = {4'h2, 32'h0, pay};
      r0 = {$urandom, $urandom};
      apply("p1_stream", 5'b00010, r0, 1'b1, 2'(i + 1), f1, 1'b1, 2'(i), f1, 1'b1, 2'(i), 1'b0);
    end

    apply("p0_sel", 5'b00001, 64'h9, 1'b1, 2'd2, 64'hFFFF_0000_FFFF_0000, 1'b1, 2'd1,
          64'h9, 1'b1, 2'd2, 1'b0);
    apply("p1_invalid_fwd", 5'b00010, 64'h1111, 1'b1, 2'd0, 64'hDEAD_BEEF, 1'b0, 2'd3,
          64'hDEAD_BEEF, 1'b0, 2'd3, 1'b0);

    apply("illegal_zero", 5'b00000, 64'hAAAA, 1'b1, 2'd1, 64'hBBBB, 1'b1, 2'd2, '0, 1'b0, 2'd0, 1'b1);
    apply("illegal_both", 5'b00011, 64'hAAAA, 1'b1, 2'd1, 64'hBBBB, 1'b1, 2'd2, '0, 1'b0, 2'd0, 1'b1);
    apply("illegal_bit4", 5'b10000, 64'hAAAA, 1'b1, 2'd1, 64'hBBBB, 1'b1, 2'd2, '0, 1'b0, 2'd0, 1'b1);
    apply("illegal_bit2", 5'b00100, 64'hAAAA, 1'b1, 2'd1, 64'hBBBB, 1'b1, 2'd2, '0, 1'b0, 2'd0, 1'b1);

    apply("switch_p0", 5'b00001, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 2'd1,
          64'h5555_5555_5555_5555, 1'b1, 2'd2, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 2'd1, 1'b0);
    apply("switch_p1", 5'b00010, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 2'd1,
          64'h5555_5555_5555_5555, 1'b1, 2'd2, 64'h5555_5555_5555_5555, 1'b1, 2'd2, 1'b0);
    apply("switch_back", 5'b00001, 64'h0123_4567_89AB_CDEF, 1'b0, 2'd3,
          64'h5555_5555_5555_5555, 1'b1, 2'd2, 64'h0123_4567_89AB_CDEF, 1'b0, 2'd3, 1'b0);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk); drain++;
    end
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected results never observed, want 0", exp_q.size());
    end

    // Mid-stream reset drops the flit held in the output register.
    @(negedge clk);
    drive_r(5'b00001, 64'hCAFE_F00D, 1'b1, 2'd1, 64'h0, 1'b0, 2'd0);
    @(posedge clk); #1;
    check("midstream_load", bus_r.odata, bus_r.ovalid, bus_r.ovch, bus_r.sel_err,
          64'hCAFE_F00D, 1'b1, 2'd1, 1'b0);
    #1 rst_ = 1'b0;
    #1 check("midstream_rst", bus_r.odata, bus_r.ovalid, bus_r.ovch, bus_r.sel_err, '0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    rst_ = 1'b1;
    drive_r(5'b00010, 64'h0, 1'b0, 2'd0, 64'h7777, 1'b1, 2'd3);
    exp_q.push_back('{"post_rst_p1", 64'h7777, 1'b1, 2'd3, 1'b0});
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk); drain++;
    end
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain2: %0d expected results never observed, want 0", exp_q.size());
    end

    // Combinational instance: results visible before the next clock edge.
    apply_c("comb_p0", 5'b00001, 64'h9, 1'b1, 2'd2, 64'h1234, 1'b1, 2'd1, 64'h9, 1'b1, 2'd2, 1'b0);
    apply_c("comb_p1", 5'b00010, 64'h9, 1'b1, 2'd2, 64'h1234, 1'b0, 2'd1, 64'h1234, 1'b0, 2'd1, 1'b0);
    apply_c("comb_illegal", 5'b00011, 64'h9, 1'b1, 2'd2, 64'h1234, 1'b1, 2'd1, '0, 1'b0, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
